// File: rtl/disp_pkg.sv
// Shared definitions for the display flip controller: FSM state encoding,
// default address width and default framebuffer geometry.
package disp_pkg;

  localparam int DISP_ADDR_W = 30;

  localparam logic [DISP_ADDR_W-1:0] DISP_BASE_ADDR  = 30'h1085557C;
  localparam logic [DISP_ADDR_W-1:0] DISP_BUF_STRIDE = 30'h0004B000;

  typedef enum logic [2:0] {
    INIT       = 3'd0,
    WAIT_FIRST = 3'd1,
    IDLE       = 3'd2,
    WAIT_VB    = 3'd3,
    CLR        = 3'd4
  } disp_state_t;

endpackage

// File: rtl/disp_buf_addr_gen.sv
// Scanned-out buffer index and its word address, advanced by a running
// accumulator (no multiplier). The buffer index wraps to 0 and reloads the base address.
module disp_buf_addr_gen
  import disp_pkg::*;
#(
  parameter int                NUM_BUF    = 2,
  parameter int                ADDR_W     = DISP_ADDR_W,
  parameter int                IDX_W      = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = DISP_BASE_ADDR,
  parameter logic [ADDR_W-1:0] BUF_STRIDE = DISP_BUF_STRIDE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              reload,
  output logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  next_idx
);

  logic [ADDR_W-1:0] next_addr;

  // Sum is truncated to ADDR_W, so the address wraps modulo 2^ADDR_W.
  always_comb begin
    next_idx  = '0;
    next_addr = BASE_ADDR;
    if (NUM_BUF > 1 && idx != IDX_W'(NUM_BUF - 1)) begin
      next_idx  = idx + 1'b1;
      next_addr = addr + BUF_STRIDE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx  <= '0;
      addr <= BASE_ADDR;
    end else if (reload) begin
      idx  <= '0;
      addr <= BASE_ADDR;
    end else if (step) begin
      idx  <= next_idx;
      addr <= next_addr;
    end
  end

endmodule

// File: rtl/disp_flip_ctrl.sv
// Display configuration sequencer with N-buffer page flipping.
// Optional DISP_FRAME_CNT_EN adds frame_cnt and missed_vb counters.
module disp_flip_ctrl
  import disp_pkg::*;
#(
  parameter int                NUM_BUF    = 2,
  parameter int                ADDR_W     = DISP_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = DISP_BASE_ADDR,
  parameter logic [ADDR_W-1:0] BUF_STRIDE = DISP_BUF_STRIDE,
  parameter int                IDX_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              VBLANK,
  output logic              CLRVBLNK,
  output logic [ADDR_W-1:0] DISPADDR,
  output logic              DISPON,
  input  logic              flip_req,
  output logic              flip_ack,
  output logic [IDX_W-1:0]  disp_idx,
  output logic [IDX_W-1:0]  draw_idx,
  output logic [2:0]        state
`ifdef DISP_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        missed_vb
`endif
);

  disp_state_t       state_q;
  logic              pending;
  logic              flip_take;
  logic              enable;
  logic [ADDR_W-1:0] cur_addr;

  assign flip_take = (state_q == WAIT_VB) && VBLANK;
  assign enable    = (state_q == WAIT_FIRST) && VBLANK;
  assign state     = state_q;

  disp_buf_addr_gen #(
    .NUM_BUF    (NUM_BUF),
    .ADDR_W     (ADDR_W),
    .IDX_W      (IDX_W),
    .BASE_ADDR  (BASE_ADDR),
    .BUF_STRIDE (BUF_STRIDE)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .step     (flip_take),
    .reload   (enable),
    .idx      (disp_idx),
    .addr     (cur_addr),
    .next_idx (draw_idx)
  );

  // The accumulator updates on the same edge DISPON rises or a flip is taken,
  // so gating it with DISPON gives the 0-until-enabled address without a copy.
  assign DISPADDR = DISPON ? cur_addr : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= INIT;
      CLRVBLNK <= 1'b1;
      DISPON   <= 1'b0;
      flip_ack <= 1'b0;
      pending  <= 1'b0;
    end else begin
      flip_ack <= 1'b0;
      // A new request in the take cycle wins over the clear.
      pending  <= flip_req | (pending & ~flip_take);
      case (state_q)
        INIT: begin
          CLRVBLNK <= 1'b0;
          state_q  <= WAIT_FIRST;
        end
        WAIT_FIRST: begin
          if (VBLANK) begin
            DISPON   <= 1'b1;
            CLRVBLNK <= 1'b1;
            state_q  <= CLR;
          end
        end
        IDLE: begin
          if (pending) state_q <= WAIT_VB;
        end
        WAIT_VB: begin
          if (VBLANK) begin
            flip_ack <= 1'b1;
            CLRVBLNK <= 1'b1;
            state_q  <= CLR;
          end
        end
        CLR: begin
          CLRVBLNK <= 1'b0;
          if (!VBLANK) state_q <= IDLE;
        end
        default: state_q <= INIT;
      endcase
    end
  end

`ifdef DISP_FRAME_CNT_EN
  logic vb_q;
  logic vb_rise;

  assign vb_rise = VBLANK & ~vb_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vb_q      <= 1'b0;
      frame_cnt <= '0;
      missed_vb <= '0;
    end else begin
      vb_q <= VBLANK;
      if (vb_rise && DISPON) frame_cnt <= frame_cnt + 16'd1;
      // A blank seen with nothing to flip is left uncleared and only counted.
      if (vb_rise && state_q == IDLE && !pending && missed_vb != 8'hFF)
        missed_vb <= missed_vb + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_disp_flip_ctrl.sv
// Directed bench for disp_flip_ctrl: three instances (2 buffers, 3 buffers,
// address-wrap geometry) share stimulus; flips are checked through an expected queue.
module tb_disp_flip_ctrl;

  localparam int W = 98;
  localparam logic [29:0] A_BASE = 30'h1085557C;
  localparam logic [29:0] A_STR  = 30'h0004B000;
  localparam logic [29:0] C_BASE = 30'h3FFFF000;
  localparam logic [29:0] C_STR  = 30'h00002000;

  logic        clk;
  logic        rst;
  logic        VBLANK;
  logic        flip_req;

  logic        a_clr, a_on, a_ack;
  logic [29:0] a_addr;
  logic [3:0]  a_disp, a_draw;
  logic [2:0]  a_state;
  logic        b_clr, b_on, b_ack;
  logic [29:0] b_addr;
  logic [3:0]  b_disp, b_draw;
  logic [2:0]  b_state;
  logic        c_clr, c_on, c_ack;
  logic [29:0] c_addr;
  logic [3:0]  c_disp, c_draw;
  logic [2:0]  c_state;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int ia = 0, ib = 0, ic = 0;

  disp_flip_ctrl u_a (
    .clk(clk), .rst(rst), .VBLANK(VBLANK), .CLRVBLNK(a_clr), .DISPADDR(a_addr),
    .DISPON(a_on), .flip_req(flip_req), .flip_ack(a_ack), .disp_idx(a_disp),
    .draw_idx(a_draw), .state(a_state)
  );

  disp_flip_ctrl #(.NUM_BUF(3)) u_b (
    .clk(clk), .rst(rst), .VBLANK(VBLANK), .CLRVBLNK(b_clr), .DISPADDR(b_addr),
    .DISPON(b_on), .flip_req(flip_req), .flip_ack(b_ack), .disp_idx(b_disp),
    .draw_idx(b_draw), .state(b_state)
  );

  disp_flip_ctrl #(.BASE_ADDR(C_BASE), .BUF_STRIDE(C_STR)) u_c (
    .clk(clk), .rst(rst), .VBLANK(VBLANK), .CLRVBLNK(c_clr), .DISPADDR(c_addr),
    .DISPON(c_on), .flip_req(flip_req), .flip_ack(c_ack), .disp_idx(c_disp),
    .draw_idx(c_draw), .state(c_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] exp_addr(input logic [29:0] base, input logic [29:0] stride,
                                          input int idx);
    logic [63:0] s;
    s = 64'(base) + 64'(stride) * 64'(idx);
    return s[29:0];
  endfunction

  // scoreboard
  task automatic push_flip();
    ia = (ia + 1) % 2;
    ib = (ib + 1) % 3;
    ic = (ic + 1) % 2;
    exp_q.push_back({4'(ia), exp_addr(A_BASE, A_STR, ia),
                     4'(ib), exp_addr(A_BASE, A_STR, ib),
                     exp_addr(C_BASE, C_STR, ic)});
  endtask

  task automatic check_pop();
    logic [W-1:0] e;
    chk("exp_q_nonempty", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("a_disp_idx", a_disp, e[97:94]);
      chk("a_dispaddr", a_addr, e[93:64]);
      chk("a_draw_idx", a_draw, (int'(e[97:94]) + 1) % 2);
      chk("b_disp_idx", b_disp, e[63:60]);
      chk("b_dispaddr", b_addr, e[59:30]);
      chk("b_draw_idx", b_draw, (int'(e[63:60]) + 1) % 3);
      chk("c_dispaddr", c_addr, e[29:0]);
      chk("bc_ack", {b_ack, c_ack}, 2'b11);
    end
  endtask

  // driver: raise VBLANK, wait for the clear pulse, then drop VBLANK
  task automatic serve_flip(input bit expect_ack);
    int n;
    VBLANK = 1'b1;
    n = 0;
    while (a_clr !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("clr_seen_in_budget", n < 20, 1);
    chk("flip_ack", a_ack, expect_ack);
    if (expect_ack) check_pop();
    VBLANK = 1'b0;
    tick();
    chk("ack_one_cycle", a_ack, 0);
    chk("clr_one_cycle", a_clr, 0);
    chk("state_idle_after_clr", a_state, 2);
  endtask

  task automatic pulse_req();
    flip_req = 1'b1;
    tick();
    flip_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    VBLANK = 1'b0;
    flip_req = 1'b0;
    #23;
    chk("rst_clr", a_clr, 1);
    chk("rst_dispaddr", a_addr, 0);
    chk("rst_dispon", a_on, 0);
    chk("rst_ack", a_ack, 0);
    chk("rst_disp_idx", a_disp, 0);
    chk("rst_draw_idx", a_draw, 1);
    chk("rst_state", a_state, 0);
    rst = 1'b1;

    // INIT -> WAIT_FIRST, then first VBLANK enables the display
    tick();
    chk("c1_state", a_state, 1);
    chk("c1_clr", a_clr, 0);
    repeat (3) tick();
    chk("wait_first_hold", a_state, 1);
    chk("wait_first_off", a_on, 0);
    VBLANK = 1'b1;
    tick();
    chk("en_dispon", a_on, 1);
    chk("en_addr_a", a_addr, A_BASE);
    chk("en_addr_c", c_addr, C_BASE);
    chk("en_clr", a_clr, 1);
    chk("en_state", a_state, 4);
    chk("en_no_ack", a_ack, 0);
    tick();
    chk("clr_first_cycle_only", a_clr, 0);
    chk("clr_hold", a_state, 4);
    VBLANK = 1'b0;
    tick();
    chk("to_idle", a_state, 2);

    // three plain flips: 2-buffer toggles, 3-buffer cycles 1,2,0, wrap geometry
    for (int k = 0; k < 3; k++) begin
      pulse_req();
      push_flip();
      repeat (2) tick();
      serve_flip(1'b1);
    end

    // burst of requests merges into one ack
    for (int k = 0; k < 3; k++) begin
      pulse_req();
      tick();
    end
    push_flip();
    serve_flip(1'b1);
    VBLANK = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("no_extra_ack", a_ack, 0);
      chk("idle_no_clear", {a_state, a_clr}, {3'd2, 1'b0});
    end
    VBLANK = 1'b0;
    tick();

    // request coincident with the taking edge is re-armed
    pulse_req();
    tick();
    chk("wait_vb", a_state, 3);
    push_flip();
    VBLANK = 1'b1;
    flip_req = 1'b1;
    tick();
    flip_req = 1'b0;
    push_flip();
    chk("coinc_ack", a_ack, 1);
    check_pop();
    VBLANK = 1'b0;
    tick();
    chk("coinc_idle", a_state, 2);
    tick();
    chk("coinc_pending_kept", a_state, 3);
    serve_flip(1'b1);

    // request with VBLANK already high: applied two clocks later
    VBLANK = 1'b1;
    tick();
    pulse_req();
    push_flip();
    chk("lat_k0_ack", a_ack, 0);
    chk("lat_k0_state", a_state, 2);
    tick();
    chk("lat_k1_ack", a_ack, 0);
    chk("lat_k1_state", a_state, 3);
    tick();
    chk("lat_k2_ack", a_ack, 1);
    chk("lat_k2_clr", a_clr, 1);
    check_pop();
    VBLANK = 1'b0;
    tick();
    chk("lat_idle", a_state, 2);

    // asynchronous reset in WAIT_VB with a pending flip
    pulse_req();
    tick();
    chk("pre_rst_wait_vb", a_state, 3);
    chk("pre_rst_on", a_on, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_clr", a_clr, 1);
    chk("arst_addr", a_addr, 0);
    chk("arst_addr_b", b_addr, 0);
    chk("arst_on", a_on, 0);
    chk("arst_ack", a_ack, 0);
    chk("arst_disp_idx", {a_disp, b_disp}, 8'h00);
    chk("arst_state", a_state, 0);
    exp_q.delete();
    ia = 0;
    ib = 0;
    ic = 0;
    #3;
    rst = 1'b1;
    tick();
    chk("rerun_c1_state", a_state, 1);
    chk("rerun_c1_clr", a_clr, 0);
    chk("rerun_c1_ack", a_ack, 0);
    serve_flip(1'b0);
    chk("rerun_on", a_on, 1);
    chk("rerun_addr", a_addr, A_BASE);
    repeat (2) tick();
    chk("pending_discarded", a_state, 2);
    chk("rerun_no_ack", a_ack, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
